aes_shift_rows_stream: RTL and testbench



---
 rtl/aes_pkg.sv | 31 +++
 rtl/aes_sr_bank.sv | 23 ++
 rtl/aes_shift_rows_stream.sv | 102 ++++++++++
 tb/tb_aes_shift_rows_stream.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte type, block size and the (Inv)ShiftRows index tables
// used by the byte-serial round stages.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [7:0] aes_byte_t;
  typedef logic [3:0] aes_idx_t;

  localparam aes_idx_t LAST_IDX = aes_idx_t'(AES_BLOCK_BYTES - 1);

  // Output index -> source index, column-major state (idx = 4*col + row).
  localparam aes_idx_t SR_MAP [AES_BLOCK_BYTES] = '{
    4'd0,  4'd5,  4'd10, 4'd15,
    4'd4,  4'd9,  4'd14, 4'd3,
    4'd8,  4'd13, 4'd2,  4'd7,
    4'd12, 4'd1,  4'd6,  4'd11
  };

  localparam aes_idx_t INV_SR_MAP [AES_BLOCK_BYTES] = '{
    4'd0,  4'd13, 4'd10, 4'd7,
    4'd4,  4'd1,  4'd14, 4'd11,
    4'd8,  4'd5,  4'd2,  4'd15,
    4'd12, 4'd9,  4'd6,  4'd3
  };

  function automatic aes_idx_t sr_src_idx(input logic inverse, input aes_idx_t out_idx);
    return inverse ? INV_SR_MAP[out_idx] : SR_MAP[out_idx];
  endfunction

endpackage

// File: rtl/aes_sr_bank.sv
// One 16-byte AES state buffer: synchronous write port, combinational read port.
module aes_sr_bank
  import aes_pkg::*;
(
  input  logic      clk,
  input  logic      wr_en,
  input  aes_idx_t  wr_addr,
  input  aes_byte_t wr_data,
  input  aes_idx_t  rd_addr,
  output aes_byte_t rd_data
);

  aes_byte_t mem [AES_BLOCK_BYTES];

  // NOTE: the storage array has no reset; the full flags in the parent decide
  // whether its contents are meaningful, so clearing it would only cost area.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/aes_shift_rows_stream.sv
// Byte-serial AES (Inv)ShiftRows stage: ping-pong buffers, one fills while the other
// drains in permuted order, valid/ready on both sides.
module aes_shift_rows_stream
  import aes_pkg::*;
#(
  parameter int BYTE_W  = 8,
  parameter bit INVERSE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last
);

  logic       wr_bank;
  logic       rd_bank;
  aes_idx_t   wr_cnt;
  aes_idx_t   rd_cnt;
  logic [1:0] bank_full;
  logic [1:0] bank_full_nxt;

  logic       in_fire;
  logic       out_fire;
  logic       wr_done;
  logic       rd_done;
  logic [1:0] bank_wr_en;
  aes_idx_t   rd_addr;
  aes_byte_t  bank_rd [2];
  aes_byte_t  rd_mux;

  assign in_ready  = !bank_full[wr_bank];
  assign out_valid = bank_full[rd_bank];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wr_done   = in_fire && (wr_cnt == LAST_IDX);
  assign rd_done   = out_fire && (rd_cnt == LAST_IDX);

  // Both banks share one read address; only the selected bank's data is used.
  assign rd_addr = sr_src_idx(INVERSE, rd_cnt);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_wr_en[b] = in_fire && !clear && (wr_bank == 1'(b));

    aes_sr_bank u_bank (
      .clk     (clk),
      .wr_en   (bank_wr_en[b]),
      .wr_addr (wr_cnt),
      .wr_data (in_data),
      .rd_addr (rd_addr),
      .rd_data (bank_rd[b])
    );
  end

  assign rd_mux   = bank_rd[rd_bank];
  assign out_data = out_valid ? rd_mux : '0;
  assign out_last = out_valid && (rd_cnt == LAST_IDX);

  // Fill-complete and drain-complete always hit different banks, so both may
  // land in the same cycle.
  // NOTE: default every always_comb output first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_done) bank_full_nxt[wr_bank] = 1'b1;
    if (rd_done) bank_full_nxt[rd_bank] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      bank_full <= '0;
    end else if (clear) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      bank_full <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      if (in_fire) begin
        wr_cnt <= wr_cnt + 4'd1;
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (out_fire) begin
        rd_cnt <= rd_cnt + 4'd1;
        if (rd_done) rd_bank <= ~rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_aes_shift_rows_stream.sv
// Directed and randomized checks of aes_shift_rows_stream, forward and inverse.
module tb_aes_shift_rows_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic       in_ready0, out_valid0, out_last0;
  logic [7:0] out_data0;
  logic       in_ready1, out_valid1, out_last1;
  logic [7:0] out_data1;

  always #5 clk = ~clk;

  aes_shift_rows_stream #(.BYTE_W(8), .INVERSE(1'b0)) dut_fwd (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_last(out_last0)
  );

  aes_shift_rows_stream #(.BYTE_W(8), .INVERSE(1'b1)) dut_inv (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1)
  );

  typedef logic [7:0] blk_t [16];
  typedef struct {
    blk_t in_b;
    blk_t exp_fwd;
    blk_t exp_inv;
  } vec_t;

  vec_t vecs [3];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // model / capture state
  logic [7:0] blk [$];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  logic [7:0] got0 [$];
  logic [7:0] got1 [$];
  logic       gotl0 [$];
  logic       gotl1 [$];
  int         fire_cyc [$];
  int         acc_cnt;
  int         last_acc_cyc;
  int         ir_low_cnt;
  bit         stall_chk;
  bit         prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] perm(input blk_t b, input int k, input bit inv);
    int r, c, src;
    r = k % 4;
    c = k / 4;
    src = inv ? (c - r + 4) % 4 : (c + r) % 4;
    return b[4 * src + r];
  endfunction

  task automatic reset_model();
    blk.delete(); exp0.delete(); exp1.delete();
    got0.delete(); got1.delete(); gotl0.delete(); gotl1.delete(); fire_cyc.delete();
    acc_cnt = 0; last_acc_cyc = -1; ir_low_cnt = 0; prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    reset_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle: sample at the falling edge, drive inputs for the next rising edge.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
    blk_t b;
    @(negedge clk);
    cyc++;
    in_valid = iv; in_data = d; out_ready = ordy; clear = clr;
    if (stall_chk && prev_stall) begin
      check("stall_data", {24'd0, out_data0}, {24'd0, prev_data});
      check("stall_last", {31'd0, out_last0}, {31'd0, prev_last});
    end
    prev_stall = out_valid0 && !ordy && !clr;
    prev_data  = out_data0;
    prev_last  = out_last0;
    if (!in_ready0) ir_low_cnt++;
    if (clr) begin
      blk.delete(); exp0.delete(); exp1.delete();
    end else begin
      if (iv && in_ready0) begin
        acc_cnt++;
        last_acc_cyc = cyc;
        blk.push_back(d);
        if (blk.size() == 16) begin
          for (int i = 0; i < 16; i++) b[i] = blk[i];
          for (int k = 0; k < 16; k++) begin
            exp0.push_back(perm(b, k, 1'b0));
            exp1.push_back(perm(b, k, 1'b1));
          end
          blk.delete();
        end
      end
      if (out_valid0 && ordy) begin
        got0.push_back(out_data0);
        got1.push_back(out_data1);
        gotl0.push_back(out_last0);
        gotl1.push_back(out_last1);
        fire_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic drain(input string name, input int n, input int budget);
    int k = 0;
    while (got0.size() < n && k < budget) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      k++;
    end
    check({name, "_drain_cnt"}, got0.size(), n);
  endtask

  task automatic compare_model(input string name);
    check({name, "_len"}, got0.size(), exp0.size());
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
      check({name, "_fwd"}, {24'd0, got0[i]}, {24'd0, exp0[i]});
      check({name, "_inv"}, {24'd0, got1[i]}, {24'd0, exp1[i]});
      check({name, "_last"}, {30'd0, gotl0[i], gotl1[i]}, {30'd0, {2{(i % 16) == 15}}});
    end
  endtask

  task automatic compare_vec(input string name, input int v, input int offset);
    for (int i = 0; i < 16; i++) begin
      if (offset + i < got0.size()) begin
        check({name, "_fwd"}, {24'd0, got0[offset + i]}, {24'd0, vecs[v].exp_fwd[i]});
        check({name, "_inv"}, {24'd0, got1[offset + i]}, {24'd0, vecs[v].exp_inv[i]});
        check({name, "_last"}, {30'd0, gotl0[offset + i], gotl1[offset + i]},
              {30'd0, {2{i == 15}}});
      end
    end
  endtask

  task automatic feed_vec(input int v, input logic ordy);
    for (int i = 0; i < 16; i++) step(1'b1, vecs[v].in_b[i], ordy, 1'b0);
  endtask

  initial begin
    int k;
    vecs[0].in_b    = '{8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,
                        8'h08,8'h09,8'h0A,8'h0B,8'h0C,8'h0D,8'h0E,8'h0F};
    vecs[0].exp_fwd = '{8'h00,8'h05,8'h0A,8'h0F,8'h04,8'h09,8'h0E,8'h03,
                        8'h08,8'h0D,8'h02,8'h07,8'h0C,8'h01,8'h06,8'h0B};
    vecs[0].exp_inv = '{8'h00,8'h0D,8'h0A,8'h07,8'h04,8'h01,8'h0E,8'h0B,
                        8'h08,8'h05,8'h02,8'h0F,8'h0C,8'h09,8'h06,8'h03};
    vecs[1].in_b    = '{8'h10,8'h11,8'h12,8'h13,8'h14,8'h15,8'h16,8'h17,
                        8'h18,8'h19,8'h1A,8'h1B,8'h1C,8'h1D,8'h1E,8'h1F};
    vecs[1].exp_fwd = '{8'h10,8'h15,8'h1A,8'h1F,8'h14,8'h19,8'h1E,8'h13,
                        8'h18,8'h1D,8'h12,8'h17,8'h1C,8'h11,8'h16,8'h1B};
    vecs[1].exp_inv = '{8'h10,8'h1D,8'h1A,8'h17,8'h14,8'h11,8'h1E,8'h1B,
                        8'h18,8'h15,8'h12,8'h1F,8'h1C,8'h19,8'h16,8'h13};
    vecs[2].in_b    = '{8'hFF,8'hFE,8'hFD,8'hFC,8'hFB,8'hFA,8'hF9,8'hF8,
                        8'hF7,8'hF6,8'hF5,8'hF4,8'hF3,8'hF2,8'hF1,8'hF0};
    vecs[2].exp_fwd = '{8'hFF,8'hFA,8'hF5,8'hF0,8'hFB,8'hF6,8'hF1,8'hFC,
                        8'hF7,8'hF2,8'hFD,8'hF8,8'hF3,8'hFE,8'hF9,8'hF4};
    vecs[2].exp_inv = '{8'hFF,8'hF2,8'hF5,8'hF8,8'hFB,8'hFE,8'hF1,8'hF4,
                        8'hF7,8'hFA,8'hFD,8'hF0,8'hF3,8'hF6,8'hF9,8'hFC};

    stall_chk = 1'b0;
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // reset values while rst is held
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_in_ready",  {30'd0, in_ready0, in_ready1},   32'd3);
    check("rst_out_valid", {30'd0, out_valid0, out_valid1}, 32'd0);
    check("rst_out_last",  {30'd0, out_last0, out_last1},   32'd0);
    check("rst_out_data",  {16'd0, out_data0, out_data1},   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // table vectors: single block, out_ready held high
    for (int v = 0; v < 3; v++) begin
      do_reset();
      feed_vec(v, 1'b1);
      drain($sformatf("vec%0d", v), 16, 40);
      compare_vec($sformatf("vec%0d", v), v, 0);
      if (fire_cyc.size() > 0)
        check($sformatf("vec%0d_latency", v), fire_cyc[0] - last_acc_cyc, 32'd1);
    end

    // both banks full -> backpressure, then drain in order
    do_reset();
    feed_vec(0, 1'b0);
    feed_vec(1, 1'b0);
    check("bp_accepted", acc_cnt, 32'd32);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    check("bp_in_ready",  {31'd0, in_ready0},  32'd0);
    check("bp_out_valid", {31'd0, out_valid0}, 32'd1);
    check("bp_out_data",  {24'd0, out_data0},  32'h00);
    check("bp_ignored",   acc_cnt, 32'd32);
    drain("bp", 32, 80);
    compare_vec("bp_blk1", 0, 0);
    compare_vec("bp_blk2", 1, 16);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("bp_ready_back", {31'd0, in_ready0}, 32'd1);

    // sustained streaming, four blocks
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b1, 8'((i * 7 + 3) & 8'hFF), 1'b1, 1'b0);
    check("stream_accepted", acc_cnt, 32'd64);
    check("stream_ready_drops", ir_low_cnt, 32'd0);
    drain("stream", 64, 40);
    if (fire_cyc.size() == 64)
      check("stream_no_bubble", fire_cyc[63] - fire_cyc[0], 32'd63);
    compare_model("stream");

    // random handshakes with stall stability
    do_reset();
    stall_chk = 1'b1;
    k = 0;
    while (acc_cnt < 64 && k < 2000) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      k++;
    end
    check("rand_accepted", acc_cnt, 32'd64);
    drain("rand", 64, 200);
    stall_chk = 1'b0;
    compare_model("rand");

    // clear drops a full bank and a partial fill
    do_reset();
    feed_vec(2, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("clr_out_valid", {31'd0, out_valid0}, 32'd0);
    check("clr_in_ready",  {31'd0, in_ready0},  32'd1);
    got0.delete(); got1.delete(); gotl0.delete(); gotl1.delete(); fire_cyc.delete();
    feed_vec(0, 1'b1);
    drain("clr", 16, 40);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("clr_no_extra", got0.size(), 32'd16);
    compare_vec("clr", 0, 0);

    // rst in the middle of a block
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
    do_reset();
    feed_vec(1, 1'b1);
    drain("mrst", 16, 40);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("mrst_no_extra", got0.size(), 32'd16);
    compare_vec("mrst", 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
